// File: rtl/rf_write_arbiter_pkg.sv
// rf_ctrl_pkg: register-file geometry and write-controller state encoding
package rf_ctrl_pkg;
    localparam int RF_AW        = 4;
    localparam int RF_DW        = 16;
    localparam int RF_NREGS     = 16;
    localparam int RF_ZERO_ADDR = 0;
    typedef enum logic {IDLE, SWEEP} rf_ctrl_state_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: bundled write-request handshake from the writeback sources
interface rf_write_arbiter_if import rf_ctrl_pkg::*; #(
    parameter int NREQ = 3,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/rf_write_arbiter_arb.sv
// rr_arbiter_n: combinational round-robin grant with a registered priority pointer
module rr_arbiter_n #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         nClear,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    logic [PW-1:0] r_rr, w_win, w_hi_idx, w_lo_idx;
    logic          w_hi, w_lo, w_hit;
    // Descending scan leaves the lowest index at/above the pointer and the lowest overall
    always_comb begin
        w_hi     = 1'b0;
        w_lo     = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && PW'(i) >= r_rr) begin
                w_hi     = 1'b1;
                w_hi_idx = PW'(i);
            end
            if (req[i]) begin
                w_lo     = 1'b1;
                w_lo_idx = PW'(i);
            end
        end
        w_win = w_hi ? w_hi_idx : w_lo_idx;
        w_hit = en && w_lo;
        grant = w_hit ? ({{(N-1){1'b0}}, 1'b1} << w_win) : '0;
    end
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) r_rr <= '0;
        else if (w_hit) r_rr <= (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin owner of the register-file write port with a zeroing sweep
module rf_write_arbiter import rf_ctrl_pkg::*; #(
    parameter int NREQ = 3,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic                clk,
    input  logic                nClear,
    rf_write_arbiter_if.slave   bus,
    input  logic                sweep_start,
    output logic                sweep_busy,
    output logic                sweep_done,
    output logic [AW-1:0]       Caddr,
    output logic [DW-1:0]       C,
    output logic                load,
    output logic                pend_valid,
    output logic [AW-1:0]       pend_addr
);
    rf_ctrl_state_t  r_state, w_next;
    logic [AW-1:0]   r_cnt, r_addr, w_addr;
    logic [DW-1:0]   r_data, w_data;
    logic            r_we, r_done, w_en, w_last;
    logic [NREQ-1:0] w_grant;
    // nClear gates the grant so ready stays low throughout reset
    assign w_en   = nClear && r_state == IDLE && !sweep_start;
    assign w_last = r_cnt == AW'(RF_NREGS - 1);
    rr_arbiter_n #(.N(NREQ)) u_arb (
        .clk    (clk),
        .nClear (nClear),
        .req    (bus.req_valid),
        .en     (w_en),
        .grant  (w_grant)
    );
    assign bus.req_ready = w_grant;
    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_addr = w_addr | (bus.req_addr[i*AW +: AW] & {AW{w_grant[i]}});
            w_data = w_data | (bus.req_data[i*DW +: DW] & {DW{w_grant[i]}});
        end
    end
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && sweep_start) w_next = SWEEP;
        else if (r_state == SWEEP && w_last) w_next = IDLE;
    end
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == SWEEP) ? r_cnt + 1'b1 : (sweep_start ? AW'(1) : r_cnt);
        end
    end
    // Address/data hold when no write is issued; only the enable drops
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            r_addr <= '0;
            r_data <= '0;
            r_we   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= r_state == SWEEP && w_last;
            if (r_state == SWEEP) begin
                r_addr <= r_cnt;
                r_data <= '0;
                r_we   <= 1'b1;
            end else if (|w_grant) begin
                r_addr <= w_addr;
                r_data <= w_data;
                r_we   <= w_addr != AW'(RF_ZERO_ADDR);
            end else begin
                r_we   <= 1'b0;
            end
        end
    end
    assign Caddr      = r_addr;
    assign C          = r_data;
    assign load       = r_we;
    assign pend_valid = r_we;
    assign pend_addr  = r_addr;
    assign sweep_busy = r_state == SWEEP;
    assign sweep_done = r_done;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: vector table, corner sequences and a queue-based random reference
module tb_rf_write_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 4;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          nClear = 1'b0;
    logic          sweep_start = 1'b0;
    logic          sweep_busy, sweep_done, load, pend_valid;
    logic [AW-1:0] Caddr, pend_addr;
    logic [DW-1:0] C;
    int            tests = 0;
    int            fails = 0;

    rf_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .nClear      (nClear),
        .bus         (bus),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .Caddr       (Caddr),
        .C           (C),
        .load        (load),
        .pend_valid  (pend_valid),
        .pend_addr   (pend_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  v;
        logic [11:0] a;
        logic [47:0] d;
        logic [2:0]  rdy;
        logic        ld;
        logic [3:0]  ca;
        logic [15:0] cd;
    } vec_t;

    vec_t        tbl[15];
    logic        pv[NREQ];
    logic [3:0]  pa[NREQ];
    logic [15:0] pd[NREQ];
    logic [11:0] ra;
    logic [47:0] rd;
    int          sq[$];
    int          m_rr, w;
    logic        m_ld, m_done, e_busy, sw, got;
    logic [3:0]  m_ca;
    logic [15:0] m_cd;
    logic [2:0]  erdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic ld, input logic [3:0] ca, input logic [15:0] cd);
        chk({tag, "_load"}, 32'(load), 32'(ld));
        chk({tag, "_caddr"}, 32'(Caddr), 32'(ca));
        chk({tag, "_c"}, 32'(C), 32'(cd));
        chk({tag, "_pend_valid"}, 32'(pend_valid), 32'(ld));
        chk({tag, "_pend_addr"}, 32'(pend_addr), 32'(ca));
    endtask

    task automatic drive(input logic [2:0] v, input logic [11:0] a, input logic [47:0] d, input logic s);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        sweep_start   = s;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nClear = 1'b0;
        drive(3'b000, 12'h000, 48'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        nClear = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 3'b000, 12'h000, 48'h0000_0000_0000, 3'b000, 1'b0, 4'h0, 16'h0000};
        tbl[1]  = '{1'b0, 3'b010, 12'h050, 48'h0000_BEEF_0000, 3'b010, 1'b0, 4'h0, 16'h0000};
        tbl[2]  = '{1'b0, 3'b000, 12'h000, 48'h0000_0000_0000, 3'b000, 1'b1, 4'h5, 16'hBEEF};
        tbl[3]  = '{1'b0, 3'b000, 12'h000, 48'h0000_0000_0000, 3'b000, 1'b0, 4'h5, 16'hBEEF};
        tbl[4]  = '{1'b1, 3'b111, 12'h963, 48'h3333_2222_1111, 3'b000, 1'b0, 4'h0, 16'h0000};
        tbl[5]  = '{1'b0, 3'b111, 12'h963, 48'h3333_2222_1111, 3'b001, 1'b0, 4'h0, 16'h0000};
        tbl[6]  = '{1'b0, 3'b111, 12'h963, 48'h3333_2222_1111, 3'b010, 1'b1, 4'h3, 16'h1111};
        tbl[7]  = '{1'b0, 3'b111, 12'h963, 48'h3333_2222_1111, 3'b100, 1'b1, 4'h6, 16'h2222};
        tbl[8]  = '{1'b0, 3'b111, 12'h963, 48'h3333_2222_1111, 3'b001, 1'b1, 4'h9, 16'h3333};
        tbl[9]  = '{1'b0, 3'b111, 12'h963, 48'h3333_2222_1111, 3'b010, 1'b1, 4'h3, 16'h1111};
        tbl[10] = '{1'b0, 3'b111, 12'h963, 48'h3333_2222_1111, 3'b100, 1'b1, 4'h6, 16'h2222};
        tbl[11] = '{1'b0, 3'b000, 12'h000, 48'h0000_0000_0000, 3'b000, 1'b1, 4'h9, 16'h3333};
        tbl[12] = '{1'b0, 3'b001, 12'h000, 48'h0000_0000_1234, 3'b001, 1'b0, 4'h9, 16'h3333};
        tbl[13] = '{1'b0, 3'b000, 12'h000, 48'h0000_0000_0000, 3'b000, 1'b0, 4'h0, 16'h1234};
        tbl[14] = '{1'b0, 3'b000, 12'h000, 48'h0000_0000_0000, 3'b000, 1'b0, 4'h0, 16'h1234};

        drive(3'b000, 12'h000, 48'h0, 1'b0);
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_busy", 32'(sweep_busy), 32'(0));
        chk("rst_done", 32'(sweep_done), 32'(0));
        chk_out("rst", 1'b0, 4'h0, 16'h0000);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            nClear = !tbl[i].rst;
            drive(tbl[i].v, tbl[i].a, tbl[i].d, 1'b0);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
            chk_out($sformatf("tbl%0d", i), tbl[i].ld, tbl[i].ca, tbl[i].cd);
            next_cycle();
        end
        nClear = 1'b1;

        // sweep with requester 2 waiting
        do_reset();
        drive(3'b100, 12'h400, 48'hABCD_0000_0000, 1'b1);
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            chk($sformatf("sw%0d_ready", k), 32'(bus.req_ready), 32'((k == 16) ? 3'b100 : 3'b000));
            chk($sformatf("sw%0d_busy", k), 32'(sweep_busy), 32'(k >= 1 && k <= 15));
            chk($sformatf("sw%0d_done", k), 32'(sweep_done), 32'(k == 16));
            if (k < 2) chk_out($sformatf("sw%0d", k), 1'b0, 4'h0, 16'h0000);
            else if (k <= 16) chk_out($sformatf("sw%0d", k), 1'b1, 4'(k - 1), 16'h0000);
            else chk_out($sformatf("sw%0d", k), 1'b1, 4'h4, 16'hABCD);
            next_cycle();
            sweep_start = 1'b0;
            if (k == 16) bus.req_valid = 3'b000;
        end

        // reset in the middle of a sweep, after moving the pointer off 0
        do_reset();
        drive(3'b001, 12'h001, 48'h0000_0000_0001, 1'b0);
        @(negedge clk);
        chk("mid_pre_ready", 32'(bus.req_ready), 32'(3'b001));
        next_cycle();
        drive(3'b000, 12'h000, 48'h0, 1'b1);
        next_cycle();
        sweep_start = 1'b0;
        repeat (7) next_cycle();
        @(negedge clk);
        chk("mid_caddr7", 32'(Caddr), 32'(7));
        nClear = 1'b0;
        #1;
        chk("mid_load", 32'(load), 32'(0));
        chk("mid_busy", 32'(sweep_busy), 32'(0));
        chk("mid_done", 32'(sweep_done), 32'(0));
        chk("mid_ready", 32'(bus.req_ready), 32'(0));
        next_cycle();
        nClear = 1'b1;
        drive(3'b101, 12'h201, 48'h0002_0000_0001, 1'b0);
        @(negedge clk);
        chk("post_rst_rr0", 32'(bus.req_ready), 32'(3'b001));
        next_cycle();
        drive(3'b000, 12'h000, 48'h0, 1'b0);

        // requester 1 held while requester 0 toggles
        do_reset();
        got = 1'b0;
        drive(3'b000, 12'h0A5, 48'h0000_00AA_0055, 1'b0);
        for (int c = 0; c < NREQ && !got; c++) begin
            bus.req_valid = {1'b0, 1'b1, (c % 2) == 0};
            @(negedge clk);
            if (bus.req_ready[1]) got = 1'b1;
            next_cycle();
        end
        chk("no_starve", 32'(got), 32'(1));
        drive(3'b000, 12'h000, 48'h0, 1'b0);

        // random traffic against the reference
        do_reset();
        m_rr = 0;
        sq.delete();
        m_ld = 1'b0;
        m_done = 1'b0;
        m_ca = 4'h0;
        m_cd = 16'h0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i] = 1'b1;
                    pa[i] = 4'($urandom_range(0, 15));
                    pd[i] = 16'($urandom);
                end
            end
            sw = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < NREQ; i++) begin
                ra[i*AW +: AW] = pa[i];
                rd[i*DW +: DW] = pd[i];
            end
            drive({pv[2], pv[1], pv[0]}, ra, rd, sw);
            @(negedge clk);
            e_busy = sq.size() > 0;
            w = -1;
            if (!e_busy && !sw)
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && pv[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
            erdy = (w >= 0) ? 3'(1 << w) : 3'b000;
            chk("rnd_ready", 32'(bus.req_ready), 32'(erdy));
            chk("rnd_busy", 32'(sweep_busy), 32'(e_busy));
            chk("rnd_done", 32'(sweep_done), 32'(m_done));
            chk_out("rnd", m_ld, m_ca, m_cd);
            m_done = 1'b0;
            if (e_busy) begin
                m_ca = 4'(sq.pop_front());
                m_cd = 16'h0;
                m_ld = 1'b1;
                m_done = sq.size() == 0;
            end else if (sw) begin
                for (int a = 1; a <= 15; a++) sq.push_back(a);
                m_ld = 1'b0;
            end else if (w >= 0) begin
                m_ca = pa[w];
                m_cd = pd[w];
                m_ld = pa[w] != 4'h0;
                m_rr = (w + 1) % NREQ;
                pv[w] = 1'b0;
            end else begin
                m_ld = 1'b0;
            end
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port controller for the 16×16-bit register file. It shares the file's single write port (`Caddr`/`C`/`load`) between `NREQ` requesters using round-robin arbitration, and it registers the winning write for one cycle before presenting it. It also runs a sweep sequence that zeroes registers 1..15 on command. It sits between the writeback sources (ALU, load unit, debug) and the register file, and it exposes the in-flight write to the hazard/forwarding logic.

## Interface
- `NREQ`, 3, number of write requesters (2..4)
- `AW`, 4, register address width
- `DW`, 16, data width
- `clk`  in  1  clock; all state updates on the rising edge
- `nClear`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  write request per requester
- `req_addr`  in  NREQ*AW  destination address; requester i uses slice [i*AW +: AW]
- `req_data`  in  NREQ*DW  write data; requester i uses slice [i*DW +: DW]
- `req_ready`  out  NREQ  combinational grant; a write is accepted when `valid & ready` is high at the edge
- `sweep_start`  in  1  single-cycle request to zero registers 1..15
- `sweep_busy`  out  1  high while the sweep is issuing writes
- `sweep_done`  out  1  one-cycle pulse, coincident with the last sweep write
- `Caddr`  out  AW  register file write address
- `C`  out  DW  register file write data
- `load`  out  1  register file write enable
- `pend_valid`  out  1  an output-stage write targets a nonzero register (equals `load`)
- `pend_addr`  out  AW  address of the pending write (equals `Caddr`)

## Operation
- States: IDLE and SWEEP.
  - IDLE→SWEEP when `sweep_start=1`; the counter loads 1.
  - SWEEP→IDLE after the counter issues 15.
  - `sweep_start` is ignored while in SWEEP.
- Arbitration happens only in IDLE with `sweep_start=0`. In all other cycles, `req_ready` is all zero.
- Round-robin arbitration:
  - Pointer `rr` ∈ [0, NREQ-1].
  - The winner is the first requester with `valid` set, scanning from `rr` upward and wrapping.
  - At most one bit of `req_ready` is high per cycle.
  - After a grant, `rr` becomes winner+1 (mod NREQ). With no grant, `rr` holds.
- Requester rule: once `valid` is asserted, `valid`, `addr` and `data` must be held stable until the write is accepted.
- Output stage: one register holding {addr, data, we}.
  - On a grant it loads {req_addr[w], req_data[w], req_addr[w]!=0}.
  - In SWEEP it loads {cnt, 0, 1}.
  - Otherwise `we` is cleared.
- A write to address 0 is accepted and retired normally but never asserts `load`, because register 0 is hard zero.
- `C` and `Caddr` keep their last values when `load=0`.

## Timing
- Reset values:
  - `load`, `pend_valid`, `sweep_busy` and `sweep_done` are 0.
  - `Caddr` and `C` are 0.
  - `rr` is 0, the state is IDLE and `cnt` is 0.
  - `req_ready` is 0 while `nClear=0`.
- Write latency:
  - A write accepted at edge E drives `load`/`Caddr`/`C` in the cycle after E.
  - The register file captures the write at E+1.
  - The new value is readable on A/B after E+1.
- Throughput is one write per cycle, sustained across requesters.
- Sweep sequence, with `sweep_start` sampled in IDLE during cycle t0:
  - No grant occurs in t0.
  - `sweep_busy=1` in t0+1..t0+15.
  - `load=1` with `Caddr`=1..15 in cycles t0+2..t0+16.
  - `sweep_done=1` in t0+16 only.
  - Grants can resume in t0+16.
- Simultaneous `sweep_start` and requests in IDLE: the sweep wins, and requests stay pending with `ready=0`.
- A write accepted in t0-1 presents in t0, so it never collides with the sweep.
- Reset mid-sweep: the controller returns to IDLE immediately, with no `sweep_done` and `load=0`.

## Structure
- Package `rf_ctrl_pkg`, containing:
  - `RF_AW=4`, `RF_DW=16`, `RF_NREGS=16`, `RF_ZERO_ADDR=0`
  - state enum `rf_ctrl_state_t` {IDLE, SWEEP}
- Sub-module `rr_arbiter_n`: parameter N, plus `clk`, `nClear`, `req[N]`, `en`, `grant[N]`. It is combinational except for the pointer, which updates only when `en` is high and a grant occurs.
- Top level: FSM, sweep counter, output stage register, and the data/address mux selected by the one-hot grant.

## Test plan
- Reset, then requester 1 writes addr 5 / 0xBEEF in cycle 3 → `req_ready`=010 in cycle 3; `load=1`, `Caddr=5`, `C=0xBEEF` in cycle 4; `load=0` in cycle 5.
- All three requesters valid continuously with distinct addresses → grants in order 0,1,2,0,1,2, and `load=1` on every cycle from the second onward.
- Requester 0 writes addr 0 / 0x1234 → `req_ready[0]=1`, `load=0` the next cycle, and `pend_valid=0`.
- `sweep_start` pulse with requester 2 valid → `req_ready`=000 for 16 cycles; `Caddr` runs 1..15 with `C=0`; `sweep_done` pulses with `Caddr=15`; `req_ready[2]=1` in the same cycle.
- `nClear` asserted low mid-sweep (at `Caddr=7`) → `load`, `sweep_busy` and `sweep_done` all 0 immediately. After release, a new request is granted with `rr=0`.
- Requester 1 holds `valid` while requester 0 toggles `valid` every cycle → requester 1 is granted within NREQ cycles, confirming there is no starvation.
